// File: rtl/div_pkg.sv
// ============================================================
// Package : div_pkg
// Desc    : shared widths, output-select codes, core states
// Rev     : 1.0
// ============================================================
`default_nettype none

package div_pkg;
    localparam int WIDTH_N = 16;
    localparam int WIDTH_D = 8;
    localparam int ITER    = 16;
    localparam int CNT_W   = $clog2(ITER + 1);

    localparam logic [1:0] OUT_SEL_QLO  = 2'b00;
    localparam logic [1:0] OUT_SEL_QHI  = 2'b01;
    localparam logic [1:0] OUT_SEL_REM  = 2'b10;
    localparam logic [1:0] OUT_SEL_STAT = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/div16_shiftsub_core.sv
// ============================================================
// Module : div16_shiftsub_core
// Desc   : restoring shift-and-subtract 16/8 unsigned divider
// Rev    : 1.0
// ============================================================
`default_nettype none

module div16_shiftsub_core
    import div_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic               dbz,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH_N-1:0] r_n;
    logic [WIDTH_D-1:0] r_d;
    logic [WIDTH_D-1:0] r_r;
    logic [WIDTH_N-1:0] r_q;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH_D:0]   w_t;
    logic               w_ge;
    logic [WIDTH_D-1:0] w_diff;

    // The partial remainder stays below the divisor after every step, so
    // the 8-bit difference is exact and r never needs its ninth bit stored.
    assign w_t    = {r_r, r_n[WIDTH_N-1]};
    assign w_ge   = (w_t >= {1'b0, r_d});
    assign w_diff = w_t[WIDTH_D-1:0] - r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !r_busy) begin
                        r_n     <= dividend;
                        r_d     <= divisor;
                        r_r     <= '0;
                        r_q     <= '0;
                        r_cnt   <= CNT_W'(ITER);
                        r_busy  <= 1'b1;
                        r_dbz   <= (divisor == '0);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_n   <= {r_n[WIDTH_N-2:0], 1'b0};
                    r_r   <= w_ge ? w_diff : w_t[WIDTH_D-1:0];
                    r_q   <= {r_q[WIDTH_N-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign dbz       = r_dbz;
    assign quotient  = r_q;
    assign remainder = r_r;

endmodule

`default_nettype wire

// File: rtl/tt_um_div16_shiftsub.sv
// ============================================================
// Module : tt_um_div16_shiftsub
// Desc   : tile wrapper: operand registers, result mux, ena gating
// Rev    : 1.0
// ============================================================
`default_nettype none

module tt_um_div16_shiftsub
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH_N-1:0] r_dvd;
    logic [WIDTH_D-1:0] r_dvs;

    logic               w_busy;
    logic               w_done;
    logic               w_dbz;
    logic [WIDTH_N-1:0] w_quo;
    logic [WIDTH_D-1:0] w_rem;
    logic [7:0]         w_sel_byte;
    logic               w_unused_uio;

    assign w_unused_uio = &{1'b0, uio_in[7:6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_dvs <= '0;
        end else begin
            if (uio_in[0]) r_dvd[7:0]  <= ui_in;
            if (uio_in[1]) r_dvd[15:8] <= ui_in;
            if (uio_in[2]) r_dvs       <= ui_in;
        end
    end

    div16_shiftsub_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (uio_in[3]),
        .dividend  (r_dvd),
        .divisor   (r_dvs),
        .busy      (w_busy),
        .done      (w_done),
        .dbz       (w_dbz),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_comb begin
        w_sel_byte = 8'h00;
        case (uio_in[5:4])
            OUT_SEL_QLO:  w_sel_byte = w_quo[7:0];
            OUT_SEL_QHI:  w_sel_byte = w_quo[15:8];
            OUT_SEL_REM:  w_sel_byte = w_rem;
            OUT_SEL_STAT: w_sel_byte = {w_busy, w_dbz, 6'b0};
            default:      w_sel_byte = 8'h00;
        endcase
    end

    assign uo_out  = w_sel_byte & {8{ena}};
    assign uio_out = {w_done & ena, w_dbz & ena, 6'b0};
    assign uio_oe  = {ena, ena, 6'b0};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_div16_shiftsub.sv
// ============================================================
// Module : tb_tt_um_div16_shiftsub
// Desc   : scoreboard bench for the 16/8 shift-subtract divider tile
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_tt_um_div16_shiftsub;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       ld_lo = 1'b0;
    logic       ld_hi = 1'b0;
    logic       ld_dvs = 1'b0;
    logic       start = 1'b0;
    logic [1:0] out_sel = 2'b00;
    logic [7:0] uio_in;

    assign uio_in = {2'b00, out_sel, start, ld_dvs, ld_hi, ld_lo};

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   k_edge = 0;
    exp_t sb[$];
    logic [15:0] m_dvd = 16'h0000;
    logic [7:0]  m_dvs = 8'h00;

    tt_um_div16_shiftsub dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        if (dvs == 8'h00) begin
            e.q   = 16'hFFFF;
            e.r   = dvd[7:0];
            e.dbz = 1'b1;
        end else begin
            e.q   = dvd / {8'h00, dvs};
            e.r   = 8'(dvd % {8'h00, dvs});
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic load_dvs(input logic [7:0] dvs);
        @(negedge clk);
        ui_in = dvs; ld_dvs = 1'b1;
        @(negedge clk);
        ld_dvs = 1'b0;
        m_dvs = dvs;
    endtask

    task automatic load(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        ui_in = dvd[7:0]; ld_lo = 1'b1;
        @(negedge clk);
        ld_lo = 1'b0; ui_in = dvd[15:8]; ld_hi = 1'b1;
        @(negedge clk);
        ld_hi = 1'b0;
        m_dvd = dvd;
        load_dvs(dvs);
    endtask

    task automatic start_div();
        @(negedge clk);
        out_sel = 2'b11;
        start = 1'b1;
        sb.push_back(model(m_dvd, m_dvs));
        @(posedge clk);
        #1;
        k_edge = cyc;
        check_val("busy_after_start", {15'd0, uo_out[7]}, 16'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (uio_out[7]) seen = 1'b1;
        end
        if (!seen) begin
            check_val("done_timeout", 16'd0, 16'd1);
        end else begin
            check_val("latency", 16'(cyc - k_edge), 16'd16);
            check_val("busy_at_done", {15'd0, uo_out[7]}, 16'd0);
        end
    endtask

    task automatic read_result();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            out_sel = 2'b00; #1;
            check_val("q_lo", {8'h00, uo_out}, {8'h00, e.q[7:0]});
            out_sel = 2'b01; #1;
            check_val("q_hi", {8'h00, uo_out}, {8'h00, e.q[15:8]});
            out_sel = 2'b10; #1;
            check_val("rem", {8'h00, uo_out}, {8'h00, e.r});
            out_sel = 2'b11; #1;
            check_val("status", {8'h00, uo_out}, {8'h00, 1'b0, e.dbz, 6'b0});
            check_val("dbz_pin", {15'd0, uio_out[6]}, {15'd0, e.dbz});
        end
    endtask

    task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs);
        load(dvd, dvs);
        start_div();
        wait_done();
        read_result();
    endtask

    initial begin
        // reset state, enabled and disabled
        #5;
        check_val("rst_uo", {8'h00, uo_out}, 16'h0000);
        check_val("rst_uio_out", {8'h00, uio_out}, 16'h0000);
        check_val("rst_uio_oe", {8'h00, uio_oe}, 16'h00C0);
        ena = 1'b0; #1;
        check_val("rst_off_uo", {8'h00, uo_out}, 16'h0000);
        check_val("rst_off_oe", {8'h00, uio_oe}, 16'h0000);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_div(16'h03E8, 8'h07);
        @(posedge clk); #1;
        check_val("done_one_cycle", {15'd0, uio_out[7]}, 16'd0);

        run_div(16'hFFFF, 8'h01);
        run_div(16'h00FF, 8'hFF);
        run_div(16'h0005, 8'h09);

        run_div(16'h1234, 8'h00);
        run_div(16'h0010, 8'h02);

        // start pulse and divisor reload while busy must not disturb the result
        load(16'h03E8, 8'h07);
        start_div();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_dvs(8'h03);
        wait_done();
        read_result();
        // start asserted in the done cycle picks up the reloaded divisor
        start_div();
        wait_done();
        read_result();

        for (int i = 0; i < 4; i++) begin
            run_div(16'($urandom), 8'($urandom_range(0, 255)));
        end

        // asynchronous reset part-way through
        load(16'h03E8, 8'h07);
        start_div();
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_status", {8'h00, uo_out}, 16'h0000);
        check_val("mid_rst_uio_out", {8'h00, uio_out}, 16'h0000);
        check_val("mid_rst_uio_oe", {8'h00, uio_oe}, 16'h00C0);
        out_sel = 2'b00; #1;
        check_val("mid_rst_qlo", {8'h00, uo_out}, 16'h0000);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_div(16'h0064, 8'h0A);

        // tile deselected during a division
        load(16'hABCD, 8'h17);
        start_div();
        repeat (3) @(negedge clk);
        ena = 1'b0;
        #1;
        check_val("ena0_uo", {8'h00, uo_out}, 16'h0000);
        check_val("ena0_uio_out", {8'h00, uio_out}, 16'h0000);
        check_val("ena0_uio_oe", {8'h00, uio_oe}, 16'h0000);
        repeat (20) @(negedge clk);
        ena = 1'b1;
        read_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
